// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the step sequencer
// Optional watchdog behaviour in step_sequencer is enabled by SEQ_WATCHDOG_EN.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_INTR,
        ST_HALTED,
        ST_STOPPED
    } seq_state_e;

    localparam logic [1:0] PH_EXEC    = 2'b00;
    localparam logic [1:0] PH_INTR    = 2'b01;
    localparam logic [1:0] PH_HALTED  = 2'b10;
    localparam logic [1:0] PH_STOPPED = 2'b11;

    localparam logic [4:0] HALT_OP_DEFAULT = 5'b11011;
    localparam int         WD_LIMIT        = 255;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - masked lowest-index-wins interrupt priority encoder
// Purely combinational; en_i gates every request (global interrupt enable).
module int_prio_enc #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic          en_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o,
    output logic [N-1:0]  onehot_o
);

    logic [N-1:0] masked;

    always_comb begin
        masked   = req_i & mask_i & {N{en_i}};
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        // Scan from the top so the lowest pending index is the last writer.
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                valid_o  = 1'b1;
                idx_o    = IW'(i);
                onehot_o = N'(1) << i;
            end
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - Mini SRC control-step sequencer with stalls, interrupts, halt/stop
// Define SEQ_WATCHDOG_EN to add the seq_err port with overrun and mem_wait watchdog.
module step_sequencer
    import seq_pkg::*;
#(
    parameter int             STEPS_MAX = 8,
    parameter int             INT_NUM   = 2,
    parameter int             INT_STEPS = 3,
    parameter int             OPW       = 5,
    parameter logic [OPW-1:0] HALT_OP   = OPW'(HALT_OP_DEFAULT),
    localparam int            SW        = width_of(STEPS_MAX),
    localparam int            IW        = width_of(INT_NUM)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Stop,
    input  logic               Start,
    input  logic [OPW-1:0]     opcode,
    input  logic               last_step,
    input  logic               mem_wait,
    input  logic [INT_NUM-1:0] interrupt,
    input  logic [INT_NUM-1:0] int_mask,
    input  logic               ie,
    output logic [SW-1:0]      step,
    output logic [1:0]         phase,
    output logic               Run,
    output logic               ClearSig,
    output logic [INT_NUM-1:0] int_ack,
    output logic [IW-1:0]      int_id
`ifdef SEQ_WATCHDOG_EN
    ,
    output logic [1:0]         seq_err
`endif
);

    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_MAX - 1);
    localparam logic [SW-1:0] INTR_LAST = SW'(INT_STEPS - 1);

    seq_state_e         state_q, state_d;
    logic [SW-1:0]      step_q, step_d;
    logic               clear_q, clear_d;
    logic [INT_NUM-1:0] ack_q, ack_d;
    logic [IW-1:0]      id_q, id_d;

    logic               pend_valid;
    logic [IW-1:0]      pend_idx;
    logic [INT_NUM-1:0] pend_onehot;
    logic               boundary;
    logic               overrun;

    int_prio_enc #(
        .N  (INT_NUM),
        .IW (IW)
    ) u_prio (
        .req_i    (interrupt),
        .mask_i   (int_mask),
        .en_i     (ie),
        .valid_o  (pend_valid),
        .idx_o    (pend_idx),
        .onehot_o (pend_onehot)
    );

`ifdef SEQ_WATCHDOG_EN
    logic [7:0] wd_q, wd_d;
    logic [1:0] err_q, err_d;
    logic       wd_trip;
`endif

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        clear_d  = 1'b0;
        ack_d    = '0;
        id_d     = id_q;
        boundary = 1'b0;
        overrun  = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                step_d  = '0;
                clear_d = 1'b1;
            end
            ST_RUN: begin
                // A stalled step ignores last_step until memory is ready.
                if (!mem_wait) begin
                    if (last_step) begin
                        boundary = 1'b1;
                    end else if (step_q == STEP_LAST) begin
                        boundary = 1'b1;
                        overrun  = 1'b1;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            ST_INTR: begin
                if (!mem_wait) begin
                    if (step_q == INTR_LAST) begin
                        state_d = ST_RUN;
                        step_d  = '0;
                        clear_d = 1'b1;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            ST_HALTED: begin
                step_d = '0;
                if (pend_valid) begin
                    state_d = ST_INTR;
                    ack_d   = pend_onehot;
                    id_d    = pend_idx;
                end else if (Start) begin
                    state_d = ST_RUN;
                end
            end
            ST_STOPPED: begin
                step_d = '0;
                if (Start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
                step_d  = '0;
            end
        endcase

        if (boundary) begin
            clear_d = 1'b1;
            step_d  = '0;
            if (opcode == HALT_OP) begin
                state_d = ST_HALTED;
            end else if (pend_valid) begin
                state_d = ST_INTR;
                ack_d   = pend_onehot;
                id_d    = pend_idx;
            end else if (Stop) begin
                state_d = ST_STOPPED;
            end else begin
                state_d = ST_RUN;
            end
        end

`ifdef SEQ_WATCHDOG_EN
        wd_trip = 1'b0;
        wd_d    = '0;
        if ((state_q == ST_RUN || state_q == ST_INTR) && mem_wait) begin
            if (wd_q == 8'(WD_LIMIT)) begin
                wd_trip = 1'b1;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end
        err_d = err_q | {wd_trip, overrun};
        // A hung memory access abandons the instruction and parks the core.
        if (wd_trip) begin
            state_d = ST_STOPPED;
            step_d  = '0;
            clear_d = 1'b1;
            ack_d   = '0;
        end
`endif
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_BOOT;
            step_q  <= '0;
            clear_q <= 1'b0;
            ack_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            clear_q <= clear_d;
            ack_q   <= ack_d;
            id_q    <= id_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wd_q  <= '0;
            err_q <= '0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign seq_err = err_q;
`endif

    always_comb begin
        phase = PH_EXEC;
        case (state_q)
            ST_INTR:    phase = PH_INTR;
            ST_HALTED:  phase = PH_HALTED;
            ST_STOPPED: phase = PH_STOPPED;
            default:    phase = PH_EXEC;
        endcase
    end

    assign Run      = (state_q == ST_RUN) || (state_q == ST_INTR);
    assign step     = step_q;
    assign ClearSig = clear_q;
    assign int_ack  = ack_q;
    assign int_id   = id_q;

endmodule
